panda_risc_v_test_monitor: RTL and testbench
============================================

Name: panda_risc_v_test_monitor

Overview:
Synthesizable, parametrised monitor that decides pass/fail for RISC-V self-checking test programs running on the panda_risc_v core. It snoops the register-file write port and, optionally, data-bus stores to a tohost address. It applies a settle window and a watchdog timeout, then reports sticky pass/fail/timeout status, the failing test number and the elapsed cycle count. It sits beside the core in the simulation/FPGA top, replacing hierarchical register peeking.

Parameters:
DONE_REG_ID, 26, GPR index whose write of 1 signals completion (1..31; 0 illegal)
RESULT_REG_ID, 27, GPR index holding result (1 = pass)
TESTNUM_REG_ID, 3, GPR index holding current test number
SETTLE_CYCLES, 10, cycles to keep tracking after completion before judging (0 allowed)
TIMEOUT_CYCLES, 1000000, watchdog limit in RUN+SETTLE cycles; 0 disables watchdog
EN_TOHOST, "false", "true" additionally enables tohost store detection
TOHOST_ADDR, 32'h0000_1000, word address (byte addr) of tohost
simulation_delay, 1, register output delay for simulation

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
en  input  1  monitoring enable; low forces IDLE
reg_wen  input  1  register-file write strobe
reg_waddr  input  5  register-file write index
reg_wdata  input  32  register-file write data
dbus_wen  input  1  data-bus store accepted (single-cycle strobe)
dbus_addr  input  32  store byte address
dbus_wdata  input  32  store data
test_done  output  1  judgement complete (sticky)
test_pass  output  1  result == 1
test_fail  output  1  result != 1 or timeout
test_timeout  output  1  watchdog expired
fail_testnum  output  32  test number at judgement (valid when test_fail)
cycle_cnt  output  32  cycles spent in RUN+SETTLE, saturating
mon_state  output  2  IDLE=0, RUN=1, SETTLE=2, DONE=3

Behaviour:
- Reset: state IDLE; all outputs, shadows and counters 0.
- en low in any state -> IDLE next edge; outputs, shadows, counters cleared (reset mid-test restarts cleanly).
- IDLE: en high -> RUN next edge; cycle_cnt, settle_cnt, shadows = 0.
- Shadow tracking (RUN and SETTLE only): reg_wen && reg_waddr==RESULT_REG_ID -> result_sh <= reg_wdata; likewise testnum_sh for TESTNUM_REG_ID. Writes with reg_waddr==0 ignored.
- RUN completion events, evaluated every edge:
  a) reg-mode: reg_wen && reg_waddr==DONE_REG_ID && reg_wdata==1.
  b) tohost (EN_TOHOST=="true"): dbus_wen && dbus_addr==TOHOST_ADDR && dbus_wdata!=0; sets result_sh = (dbus_wdata==1) ? 1 : 0, testnum_sh = dbus_wdata>>1; further tohost stores ignored.
  Both in same cycle -> b wins. Either -> SETTLE, settle_cnt=0.
- SETTLE: settle_cnt increments each edge; when settle_cnt==SETTLE_CYCLES -> DONE. SETTLE_CYCLES=0 -> DONE on first SETTLE edge. Result writes during SETTLE still update shadows (reg-mode only; tohost-captured values are frozen).
- Timing: event sampled at edge E -> mon_state=SETTLE after E; test_done high after edge E+SETTLE_CYCLES+1.
- Watchdog: cycle_cnt increments in RUN and SETTLE, saturates at 32'hFFFF_FFFF. TIMEOUT_CYCLES!=0 and cycle_cnt reaches TIMEOUT_CYCLES-1 while counting -> DONE with test_timeout=1, test_fail=1, test_pass=0, fail_testnum=testnum_sh. Completion event on the same edge wins over timeout; timeout in SETTLE also aborts to DONE.
- DONE entry (non-timeout): test_pass = (result_sh==1); test_fail = !test_pass; fail_testnum = test_fail ? testnum_sh : 0; test_done=1. All DONE outputs sticky; cycle_cnt frozen; all inputs ignored until en low or rst.
- test_pass and test_fail never both 1; both 0 whenever test_done=0.
- mon_state never takes value outside 0..3.

Test Plan:
- Reg-mode pass: en=1; write x27=1, then x26=1 at edge 100 -> SETTLE at 100, test_done/test_pass=1 after edge 111, cycle_cnt frozen, fail_testnum=0.
- Reg-mode fail: x3=5, x27=0, x26=1 -> after 11 edges test_fail=1, fail_testnum=5; x27=1 written inside settle window -> test_pass=1 instead.
- Tohost (EN_TOHOST="true"): store 0x0000_000B to 0x1000 -> test_fail=1, fail_testnum=5; store 0x1 -> test_pass=1; same-cycle x26=1 with tohost fail -> fail wins.
- Watchdog: TIMEOUT_CYCLES=50, no completion -> test_timeout=test_fail=test_done=1 at cycle_cnt=49; done event exactly on that edge -> SETTLE, no timeout.
- Edge cases: SETTLE_CYCLES=0 -> test_done one edge after SETTLE; writes to x0 and x26=2 ignored; x26=1 while en=0 ignored.
- Reset/enable mid-operation: assert rst asynchronously in SETTLE -> all outputs 0 immediately; drop en in DONE -> IDLE, outputs cleared next edge, re-enable reruns cleanly.

Source files
------------

// File: rtl/panda_risc_v_test_monitor.sv
// Pass/fail monitor for panda_risc_v self-checking test programs.
// Snoops GPR writes (and optionally tohost stores) and reports sticky status.
module panda_risc_v_test_monitor #(
    parameter int unsigned DONE_REG_ID      = 26,
    parameter int unsigned RESULT_REG_ID    = 27,
    parameter int unsigned TESTNUM_REG_ID   = 3,
    parameter int unsigned SETTLE_CYCLES    = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000,
    parameter string       EN_TOHOST        = "false",
    parameter logic [31:0] TOHOST_ADDR      = 32'h0000_1000,
    parameter int unsigned simulation_delay = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        reg_wen,
    input  logic [4:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        dbus_wen,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    output logic        test_done,
    output logic        test_pass,
    output logic        test_fail,
    output logic        test_timeout,
    output logic [31:0] fail_testnum,
    output logic [31:0] cycle_cnt,
    output logic [1:0]  mon_state
);

    localparam logic [4:0]  DONE_ID    = 5'(DONE_REG_ID);
    localparam logic [4:0]  RES_ID     = 5'(RESULT_REG_ID);
    localparam logic [4:0]  TN_ID      = 5'(TESTNUM_REG_ID);
    localparam logic [31:0] SETTLE_LIM = 32'(SETTLE_CYCLES);
    localparam logic [31:0] TO_LIM     = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam bit          WD_ON      = (TIMEOUT_CYCLES != 0);
    localparam bit          TH_ON      = (EN_TOHOST == "true");

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] res_q, res_d;
    logic [31:0] tn_q, tn_d;
    logic [31:0] ftn_q, ftn_d;
    logic        th_q, th_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        to_q, to_d;

    logic        wr_res, wr_tn, ev_reg, ev_th, wd_hit;
    logic [31:0] cyc_inc;

    always_comb begin
        wr_res  = reg_wen && (reg_waddr != 5'd0) && (reg_waddr == RES_ID);
        wr_tn   = reg_wen && (reg_waddr != 5'd0) && (reg_waddr == TN_ID);
        ev_reg  = reg_wen && (reg_waddr == DONE_ID) && (reg_wdata == 32'd1);
        ev_th   = TH_ON && dbus_wen && (dbus_addr == TOHOST_ADDR)
                  && (dbus_wdata != 32'd0);
        wd_hit  = WD_ON && (cyc_q == TO_LIM);
        cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

        state_d  = state_q;
        cyc_d    = cyc_q;
        settle_d = settle_q;
        res_d    = res_q;
        tn_d     = tn_q;
        ftn_d    = ftn_q;
        th_d     = th_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        to_d     = to_q;

        if (!en || state_q == IDLE) begin
            state_d  = en ? RUN : IDLE;
            cyc_d    = '0;
            settle_d = '0;
            res_d    = '0;
            tn_d     = '0;
            ftn_d    = '0;
            th_d     = 1'b0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            fail_d   = 1'b0;
            to_d     = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (wr_res) res_d = reg_wdata;
                    if (wr_tn)  tn_d  = reg_wdata;
                    cyc_d = cyc_inc;
                    // tohost outranks the done register on the same edge
                    if (ev_th) begin
                        res_d = {31'd0, dbus_wdata == 32'd1};
                        tn_d  = dbus_wdata >> 1;
                        th_d  = 1'b1;
                    end
                    if (ev_th || ev_reg) begin
                        state_d  = SETTLE;
                        settle_d = '0;
                    end else if (wd_hit) begin
                        state_d = DONE;
                        cyc_d   = cyc_q;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        to_d    = 1'b1;
                        pass_d  = 1'b0;
                        ftn_d   = tn_q;
                    end
                end
                SETTLE: begin
                    if (!th_q && wr_res) res_d = reg_wdata;
                    if (!th_q && wr_tn)  tn_d  = reg_wdata;
                    cyc_d = cyc_inc;
                    if (settle_q == SETTLE_LIM) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (res_q == 32'd1);
                        fail_d  = (res_q != 32'd1);
                        ftn_d   = (res_q != 32'd1) ? tn_q : 32'd0;
                    end else if (wd_hit) begin
                        state_d = DONE;
                        cyc_d   = cyc_q;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        to_d    = 1'b1;
                        pass_d  = 1'b0;
                        ftn_d   = tn_q;
                    end else begin
                        settle_d = settle_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            settle_q <= '0;
            res_q    <= '0;
            tn_q     <= '0;
            ftn_q    <= '0;
            th_q     <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            settle_q <= settle_d;
            res_q    <= res_d;
            tn_q     <= tn_d;
            ftn_q    <= ftn_d;
            th_q     <= th_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            to_q     <= to_d;
        end
    end

    assign test_done    = done_q;
    assign test_pass    = pass_q;
    assign test_fail    = fail_q;
    assign test_timeout = to_q;
    assign fail_testnum = ftn_q;
    assign cycle_cnt    = cyc_q;
    assign mon_state    = state_q;

endmodule

// File: tb/tb_panda_risc_v_test_monitor.sv
// Bench for panda_risc_v_test_monitor: two configurations side by side,
// randomized filler traffic checked against a behavioural model.
module tb_panda_risc_v_test_monitor;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        reg_wen, dbus_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, dbus_addr, dbus_wdata;

    logic        a_done, a_pass, a_fail, a_to;
    logic [31:0] a_ftn, a_cyc;
    logic [1:0]  a_st;
    logic        b_done, b_pass, b_fail, b_to;
    logic [31:0] b_ftn, b_cyc;
    logic [1:0]  b_st;

    int total = 0;
    int bad   = 0;

    // instance 0: tohost on, 10-cycle settle, no watchdog
    panda_risc_v_test_monitor #(
        .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(0), .EN_TOHOST("true")
    ) u_a (
        .clk(clk), .rst(rst), .en(en),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .dbus_wen(dbus_wen), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .test_done(a_done), .test_pass(a_pass), .test_fail(a_fail),
        .test_timeout(a_to), .fail_testnum(a_ftn), .cycle_cnt(a_cyc),
        .mon_state(a_st)
    );

    // instance 1: reg-mode only, zero settle, 50-cycle watchdog
    panda_risc_v_test_monitor #(
        .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(50), .EN_TOHOST("false")
    ) u_b (
        .clk(clk), .rst(rst), .en(en),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .dbus_wen(dbus_wen), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .test_done(b_done), .test_pass(b_pass), .test_fail(b_fail),
        .test_timeout(b_to), .fail_testnum(b_ftn), .cycle_cnt(b_cyc),
        .mon_state(b_st)
    );

    always #5 clk = ~clk;

    // model state: phase 0 idle, 1 running, 2 settling, 3 judged
    int          m_ph[2];
    int          m_left[2];
    bit          m_frz[2];
    logic [31:0] m_cyc[2], m_res[2], m_tn[2], m_ftn[2];
    logic        m_done[2], m_pass[2], m_fail[2], m_to[2];

    function automatic int settle_of(input int i);
        return (i == 0) ? 10 : 0;
    endfunction

    function automatic int limit_of(input int i);
        return (i == 0) ? 0 : 50;
    endfunction

    task automatic mclr(input int i);
        m_ph[i] = 0; m_left[i] = 0; m_frz[i] = 0;
        m_cyc[i] = 0; m_res[i] = 0; m_tn[i] = 0; m_ftn[i] = 0;
        m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_to[i] = 0;
    endtask

    task automatic mshadow(input int i);
        if (reg_wen && reg_waddr == 5'd27) m_res[i] = reg_wdata;
        if (reg_wen && reg_waddr == 5'd3)  m_tn[i]  = reg_wdata;
    endtask

    task automatic mtimeout(input int i, input logic [31:0] tn);
        m_ph[i] = 3; m_done[i] = 1; m_fail[i] = 1; m_to[i] = 1;
        m_pass[i] = 0; m_ftn[i] = tn;
    endtask

    task automatic mmodel(input int i);
        logic [31:0] r0, t0;
        bit tmo, ev_th, ev_dn;
        if (rst || !en) begin
            mclr(i);
            return;
        end
        r0    = m_res[i];
        t0    = m_tn[i];
        tmo   = (limit_of(i) != 0) && (m_cyc[i] == 32'(limit_of(i) - 1));
        ev_th = (i == 0) && dbus_wen && dbus_addr == 32'h1000
                && dbus_wdata != 0;
        ev_dn = reg_wen && reg_waddr == 5'd26 && reg_wdata == 32'd1;
        case (m_ph[i])
            0: begin
                mclr(i);
                m_ph[i] = 1;
            end
            1: begin
                mshadow(i);
                if (ev_th) begin
                    m_res[i] = (dbus_wdata == 1) ? 32'd1 : 32'd0;
                    m_tn[i]  = dbus_wdata >> 1;
                    m_frz[i] = 1;
                end
                if (ev_th || ev_dn) begin
                    m_ph[i] = 2; m_left[i] = settle_of(i); m_cyc[i]++;
                end else if (tmo) begin
                    mtimeout(i, t0);
                end else begin
                    m_cyc[i]++;
                end
            end
            2: begin
                if (!m_frz[i]) mshadow(i);
                if (m_left[i] == 0) begin
                    m_ph[i] = 3; m_done[i] = 1; m_cyc[i]++;
                    m_pass[i] = (r0 == 1);
                    m_fail[i] = (r0 != 1);
                    m_ftn[i]  = (r0 != 1) ? t0 : 32'd0;
                end else if (tmo) begin
                    mtimeout(i, t0);
                end else begin
                    m_left[i]--; m_cyc[i]++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_done", 32'(a_done), 32'(m_done[0]));
        check("a_pass", 32'(a_pass), 32'(m_pass[0]));
        check("a_fail", 32'(a_fail), 32'(m_fail[0]));
        check("a_to",   32'(a_to),   32'(m_to[0]));
        check("a_ftn",  a_ftn,       m_ftn[0]);
        check("a_cyc",  a_cyc,       m_cyc[0]);
        check("a_st",   32'(a_st),   32'(m_ph[0]));
        check("b_done", 32'(b_done), 32'(m_done[1]));
        check("b_pass", 32'(b_pass), 32'(m_pass[1]));
        check("b_fail", 32'(b_fail), 32'(m_fail[1]));
        check("b_to",   32'(b_to),   32'(m_to[1]));
        check("b_ftn",  b_ftn,       m_ftn[1]);
        check("b_cyc",  b_cyc,       m_cyc[1]);
        check("b_st",   32'(b_st),   32'(m_ph[1]));
    endtask

    task automatic step();
        @(posedge clk);
        mmodel(0);
        mmodel(1);
        #1;
        check_all();
    endtask

    task automatic quiet();
        reg_wen = 0; reg_waddr = 0; reg_wdata = 0;
        dbus_wen = 0; dbus_addr = 0; dbus_wdata = 0;
    endtask

    task automatic noise();
        int r;
        r = $urandom_range(0, 9);
        reg_wen = (r < 6);
        do reg_waddr = 5'($urandom_range(0, 31));
        while (reg_waddr == 5'd26 || reg_waddr == 5'd27 || reg_waddr == 5'd3);
        reg_wdata  = $urandom;
        dbus_wen   = (r == 7 || r == 8);
        dbus_addr  = (r == 8) ? 32'h1000 : ($urandom | 32'h0001_0000);
        dbus_wdata = (r == 8) ? 32'd0 : $urandom;
        if (r == 9) begin
            reg_wen = 1; reg_waddr = 5'd26; reg_wdata = 32'd2;
        end
    endtask

    task automatic noise_steps(input int n);
        for (int k = 0; k < n; k++) begin
            noise();
            step();
        end
        quiet();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        quiet();
        reg_wen = 1; reg_waddr = a; reg_wdata = d;
        step();
        quiet();
    endtask

    task automatic restart();
        quiet();
        en = 0;
        step();
        en = 1;
        step();
    endtask

    initial begin
        int guard;
        mclr(0);
        mclr(1);
        quiet();
        en  = 0;
        rst = 1;
        #1;
        check_all();
        step();
        step();
        #2 rst = 0;
        step();

        // reg-mode pass with the done write late in the run
        en = 1;
        step();
        wr(5'd27, 32'd1);
        noise_steps(95);
        wr(5'd26, 32'd1);
        check("a_settle_entry", 32'(a_st), 32'd2);
        noise_steps(11);
        check("a_reg_pass", 32'(a_pass), 32'd1);
        check("a_reg_pass_ftn", a_ftn, 32'd0);
        noise_steps(3);

        // reg-mode fail, then result corrected inside the settle window
        restart();
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        noise_steps(11);
        check("a_reg_fail", 32'(a_fail), 32'd1);
        check("a_reg_fail_ftn", a_ftn, 32'd5);
        restart();
        wr(5'd3, 32'd7);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        noise_steps(3);
        wr(5'd27, 32'd1);
        noise_steps(10);
        check("a_late_pass", 32'(a_pass), 32'd1);

        // tohost stores, including a same-edge race with the done register
        restart();
        noise_steps(5);
        dbus_wen = 1; dbus_addr = 32'h1000; dbus_wdata = 32'h0000_000B;
        step();
        quiet();
        noise_steps(2);
        wr(5'd27, 32'd1);
        noise_steps(10);
        check("a_th_fail_ftn", a_ftn, 32'd5);
        restart();
        dbus_wen = 1; dbus_addr = 32'h1000; dbus_wdata = 32'd1;
        step();
        noise_steps(12);
        check("a_th_pass", 32'(a_pass), 32'd1);
        restart();
        wr(5'd27, 32'd1);
        dbus_wen = 1; dbus_addr = 32'h1000; dbus_wdata = 32'h0000_000B;
        reg_wen = 1; reg_waddr = 5'd26; reg_wdata = 32'd1;
        step();
        noise_steps(12);
        check("a_race_fail", 32'(a_fail), 32'd1);

        // watchdog expiry, then a done write on the expiry edge itself
        restart();
        noise_steps(60);
        check("b_timeout", 32'(b_to), 32'd1);
        check("b_timeout_cyc", b_cyc, 32'd49);
        restart();
        guard = 0;
        while (m_cyc[1] != 32'd49 && guard < 100) begin
            noise();
            step();
            guard++;
        end
        check("b_wd_guard", 32'(guard < 100), 32'd1);
        wr(5'd26, 32'd1);
        check("b_edge_settle", 32'(b_st), 32'd2);
        check("b_edge_no_to", 32'(b_to), 32'd0);
        step();
        check("b_zero_settle", 32'(b_done), 32'd1);

        // ignored writes: x0, x26 != 1, and done while disabled
        restart();
        wr(5'd0, 32'd1);
        wr(5'd26, 32'd2);
        check("a_ignored", 32'(a_st), 32'd1);
        quiet();
        en = 0;
        step();
        reg_wen = 1; reg_waddr = 5'd26; reg_wdata = 32'd1;
        step();
        check("a_en_low", 32'(a_st), 32'd0);

        // asynchronous reset while settling
        quiet();
        en = 1;
        step();
        wr(5'd26, 32'd1);
        noise_steps(3);
        rst = 1;
        #1;
        mclr(0);
        mclr(1);
        check_all();
        step();
        #2 rst = 0;
        step();

        // drop enable in DONE, then rerun cleanly
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        noise_steps(12);
        en = 0;
        step();
        check("a_dis_clear", a_cyc, 32'd0);
        en = 1;
        noise_steps(8);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        noise_steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
